// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shifts one byte out on device clock falls.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN; otherwise only reset_n recovers a stalled transfer.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int CW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          par, par_nxt;
    logic          ack_ok, ack_ok_nxt;
    logic          clk_oe_q, clk_oe_nxt;
    logic          data_oe_q, data_oe_nxt;
    logic          done_q, done_nxt;
    logic          err_q, err_nxt;

    logic clk_meta, clk_s, clk_s_prev;
    logic data_meta, data_s;
    logic fall;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt, tcnt_nxt;
`endif

    assign fall     = clk_s_prev & ~clk_s;
    assign tx_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign tx_done  = done_q;
    assign tx_error = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

    // Synchronisers reset to the released (high) line level so reset never fabricates a fall.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_meta   <= 1'b1;
            clk_s      <= 1'b1;
            clk_s_prev <= 1'b1;
            data_meta  <= 1'b1;
            data_s     <= 1'b1;
        end else begin
            clk_meta   <= ps2_clk_in;
            clk_s      <= clk_meta;
            clk_s_prev <= clk_s;
            data_meta  <= ps2_data_in;
            data_s     <= data_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            ack_ok    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            par       <= par_nxt;
            ack_ok    <= ack_ok_nxt;
            clk_oe_q  <= clk_oe_nxt;
            data_oe_q <= data_oe_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt_nxt;
        end
    end
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        par_nxt     = par;
        ack_ok_nxt  = ack_ok;
        clk_oe_nxt  = clk_oe_q;
        data_oe_nxt = data_oe_q;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;

        case (state)
            S_IDLE: begin
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
                if (tx_valid) begin
                    state_nxt   = S_INHIBIT;
                    cnt_nxt     = '0;
                    bit_cnt_nxt = '0;
                    shreg_nxt   = tx_data;
                    par_nxt     = ~^tx_data;
                    ack_ok_nxt  = 1'b0;
                    clk_oe_nxt  = 1'b1;
                end
            end
            S_INHIBIT: begin
                clk_oe_nxt = 1'b1;
                if (cnt == INH_LAST) begin
                    clk_oe_nxt  = 1'b0;
                    data_oe_nxt = 1'b1;
                    state_nxt   = S_RTS;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_RTS: begin
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b1;
                if (fall) begin
                    data_oe_nxt = ~shreg[0];
                    bit_cnt_nxt = 4'd1;
                    state_nxt   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (fall) begin
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt <= 4'd7) begin
                        data_oe_nxt = ~shreg[bit_cnt[2:0]];
                    end else if (bit_cnt == 4'd8) begin
                        data_oe_nxt = ~par;
                    end else begin
                        data_oe_nxt = 1'b0;
                        state_nxt   = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (fall) begin
                    ack_ok_nxt = ~data_s;
                    state_nxt  = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_nxt  = ack_ok;
                    err_nxt   = ~ack_ok;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog spans every state where the device owns the clock; it overrides normal progress.
        tcnt_nxt = '0;
        if (state == S_RTS || state == S_SHIFT || state == S_ACK || state == S_WAIT_IDLE) begin
            if (fall) begin
                tcnt_nxt = '0;
            end else if (tcnt == TMO_LAST) begin
                tcnt_nxt    = '0;
                state_nxt   = S_IDLE;
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
                done_nxt    = 1'b0;
                err_nxt     = 1'b1;
            end else begin
                tcnt_nxt = tcnt + 1'b1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device that clocks frames and ACKs/NACKs them.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int TMO = 5000;
    localparam int H   = 40;   // device half clock period in system cycles

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error), .busy(busy),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0, err_cnt = 0, frame_cnt = 0;
    logic prev_clk_oe = 1'b0;

    always @(negedge clk) begin
        if (tx_done)  done_cnt++;
        if (tx_error) err_cnt++;
        if (ps2_clk_oe && !prev_clk_oe) frame_cnt++;
        prev_clk_oe = ps2_clk_oe;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        while (!tx_ready && t < 2000) begin tick(1); t++; end
        if (!tx_ready) check("send_ready", 0, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // Behavioural device: counts inhibit time, clocks 11 falls, samples on rises, answers ACK/NACK.
    task automatic dev_frame(input bit nack, input int max_falls,
                             output logic [9:0] bits, output int inh_len, output bit ok);
        int t;
        ok = 1'b1;
        bits = '0;
        inh_len = 0;
        t = 0;
        while (!ps2_clk_oe && t < 200) begin tick(1); t++; end
        if (!ps2_clk_oe) begin ok = 1'b0; return; end
        while (ps2_clk_oe && inh_len < INH * 3) begin inh_len++; tick(1); end
        check("rts_data_low", int'(ps2_data_in), 0);
        tick(H);
        for (int i = 0; i < 11; i++) begin
            dev_clk_low = 1'b1;
            if (i + 1 == max_falls) begin tick(5); return; end
            tick(H);
            dev_clk_low = 1'b0;
            if (i < 10) bits[i] = ps2_data_in;
            if (i == 9) begin
                tick(H / 2);
                dev_data_low = !nack;
                tick(H / 2);
            end else if (i == 10) begin
                tick(H);
                dev_data_low = 1'b0;
                tick(H / 2);
            end else begin
                tick(H);
            end
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input bit nack,
                             input int exp_par, input int exp_done, input int exp_err);
        int d0, e0, f0, inh;
        logic [9:0] bits;
        bit ok;
        d0 = done_cnt; e0 = err_cnt; f0 = frame_cnt;
        send(b);
        dev_frame(nack, 0, bits, inh, ok);
        tick(20);
        check({tag, "_started"}, int'(ok), 1);
        check({tag, "_inhibit_len"}, inh, INH);
        check({tag, "_byte"}, int'(bits[7:0]), int'(b));
        check({tag, "_parity"}, int'(bits[8]), exp_par);
        check({tag, "_stop"}, int'(bits[9]), 1);
        check({tag, "_done"}, done_cnt - d0, exp_done);
        check({tag, "_error"}, err_cnt - e0, exp_err);
        check({tag, "_ready"}, int'(tx_ready), 1);
        check({tag, "_frames"}, frame_cnt - f0, 1);
    endtask

    typedef struct {
        string      tag;
        logic [7:0] data;
        bit         nack;
        int         exp_par;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int d0, e0, f0, inh, n;
        logic [9:0] bits;
        bit ok;
        logic [7:0] rb;
        bit rn;

        vecs[0] = '{"ed", 8'hED, 1'b0, 1, 1, 0};
        vecs[1] = '{"01", 8'h01, 1'b0, 0, 1, 0};
        vecs[2] = '{"ff", 8'hFF, 1'b0, 1, 1, 0};
        vecs[3] = '{"00", 8'h00, 1'b0, 1, 1, 0};
        vecs[4] = '{"f4_nack", 8'hF4, 1'b1, 0, 0, 1};

        reset_n = 1'b0;
        tick(3);
        check("rst_ready", int'(tx_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_clk_oe", int'(ps2_clk_oe), 0);
        check("rst_data_oe", int'(ps2_data_oe), 0);
        check("rst_done_err", int'(tx_done) + int'(tx_error), 0);
        reset_n = 1'b1;
        tick(3);

        foreach (vecs[i])
            run_frame(vecs[i].tag, vecs[i].data, vecs[i].nack,
                      vecs[i].exp_par, vecs[i].exp_done, vecs[i].exp_err);

        // Reset just after the 4th device fall.
        d0 = done_cnt; e0 = err_cnt;
        send(8'hA5);
        dev_frame(1'b0, 4, bits, inh, ok);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check("midrst_clk_oe", int'(ps2_clk_oe), 0);
        check("midrst_data_oe", int'(ps2_data_oe), 0);
        check("midrst_ready", int'(tx_ready), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_pulses", int'(tx_done) + int'(tx_error), 0);
        dev_clk_low = 1'b0;
        tick(50);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_no_err", err_cnt - e0, 0);
        run_frame("after_rst", 8'h5A, 1'b0, 1, 1, 0);

        // Request while busy must be dropped.
        d0 = done_cnt; f0 = frame_cnt;
        send(8'h3C);
        fork
            dev_frame(1'b0, 0, bits, inh, ok);
            begin
                tick(30);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                tick(300);
                tx_valid = 1'b0;
            end
        join
        tick(300);
        check("busy_byte", int'(bits[7:0]), 8'h3C);
        check("busy_done", done_cnt - d0, 1);
        check("busy_frames", frame_cnt - f0, 1);
        check("busy_ready", int'(tx_ready), 1);

        // Randomised frames against the parity/ACK reference model.
        for (int k = 0; k < 6; k++) begin
            rb = 8'($urandom);
            rn = 1'($urandom_range(0, 1));
            run_frame($sformatf("rand%0d", k), rb, rn,
                      ($countones(rb) % 2 == 0) ? 1 : 0, rn ? 0 : 1, rn ? 1 : 0);
        end

`ifdef PS2_TX_TIMEOUT_EN
        e0 = err_cnt;
        send(8'h12);
        n = 0;
        while (ps2_clk_oe && n < INH * 3) begin tick(1); n++; end
        n = 0;
        while (!tx_error && n < TMO + 100) begin tick(1); n++; end
        check("tmo_cycles", n, TMO);
        check("tmo_clk_oe", int'(ps2_clk_oe), 0);
        check("tmo_data_oe", int'(ps2_data_oe), 0);
        tick(5);
        check("tmo_err_pulses", err_cnt - e0, 1);
        check("tmo_ready", int'(tx_ready), 1);
`else
        e0 = err_cnt;
        send(8'h12);
        tick(10000);
        check("hang_busy", int'(busy), 1);
        check("hang_no_err", err_cnt - e0, 0);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check("hang_recover_ready", int'(tx_ready), 1);
        check("hang_recover_oe", int'(ps2_clk_oe) + int'(ps2_data_oe), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
